alu_decode: RTL and testbench
=============================

# alu_decode

Decode-stage producer for the execute-stage ALU. It takes fetched RV64I instructions over a valid/ready handshake and translates every ALU-class opcode into an `alufunc_t` plus operand selects, the immediate and register indices. Results are held in a one-entry pipeline register with stall and flush support. It sits between fetch and the execute stage, so every encoding the ALU accepts has exactly one decode path here.

## Interface
- No parameters.
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-high.
- `flush  in  1`: drop the held entry and any entry offered this cycle.
- `in_valid  in  1`, `in_ready  out  1`: upstream handshake.
- `in_instr  in  32`, `in_pc  in  64`: instruction word and its PC.
- `out_valid  out  1`, `out_ready  in  1`: downstream handshake.
- `out_alufunc  out  alufunc_t`: ALU operation.
- `out_srca_pc  out  1`: operand a is PC (1) or rs1 (0).
- `out_srcb_imm  out  1`: operand b is imm (1) or rs2 (0).
- `out_imm  out  64`: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd  out  5 each`: register indices.
- `out_regwrite  out  1`: legal and rd≠0.
- `out_illegal  out  1`: unsupported encoding.
- `out_pc  out  64`, `out_instr  out  32`: passthrough.

## Operation
- **OP-IMM (0010011).** funct3 maps as follows:
  - 000→ADD, 010→SLTI, 011→SLTIU, 100→XOR, 110→OR, 111→AND.
  - 001→SLLI; requires instr[31:26]=000000.
  - 101→SRLI if instr[31:26]=000000, SRAI if 010000.
  - Immediate is sext(instr[31:20]). For shifts, imm={58'b0,instr[25:20]}.
  - srcb_imm=1.
- **OP (0110011), funct7=0000000.** 000 ADD, 001 SLLI, 010 SLTI, 011 SLTIU, 100 XOR, 101 SRLI, 110 OR, 111 AND.
- **OP, funct7=0100000.** 000 SUB, 101 SRAI.
- **OP, any other funct7** (including 0000001, the M extension) is illegal.
- **OP-IMM-32 (0011011).** 000→ADDW. 001→SLLW, requires funct7=0. 101→SRLW if funct7=0, SRAW if 0100000. Immediate: sext(instr[31:20]) for ADDIW, {59'b0,instr[24:20]} for shifts. instr[25]=1 on a shift is illegal.
- **OP-32 (0111011).** 000 ADDW (funct7 0) or SUBW (0100000), 001 SLLW, 101 SRLW/SRAW. Any other funct3/funct7 combination is illegal.
- **LUI (0110111).** ALU_COPYB, imm=sext({instr[31:12],12'b0}), srcb_imm=1.
- **AUIPC (0010111).** ALU_ADD, srca_pc=1, same imm as LUI.
- **All other opcodes and unlisted funct3/funct7 combinations.** illegal=1, regwrite=0, alufunc=ALU_COPYB, imm=0. The entry still flows downstream.
- **Register fields.** rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], always extracted raw.

## Timing
- Decode logic is combinational on `in_instr`. All outputs are registered, giving 1-cycle latency from accept to `out_valid`.
- `in_ready = !out_valid || out_ready`, combinational.
- Accept occurs when `in_valid && in_ready`. Payload is captured at the edge and `out_valid` is set.
- If `out_valid && out_ready` and there is no accept, `out_valid` clears.
- If `out_valid && !out_ready`, all out_* hold stable. Verified against a changing `in_instr`.
- Back-to-back: a new instruction is accepted in the same cycle the old one drains. Full throughput is 1 per cycle.
- `flush=1`: `out_valid` is 0 after the edge, regardless of `in_valid`/`out_ready`. Flush wins over a simultaneous accept, and the input is consumed and discarded.
- Reset, including mid-stall: all outputs 0 asynchronously and `out_valid`=0. The first accept is possible on the first edge after deassertion.

## Structure
- Add `ALU_COPYB` to `alufunc_t` in `pipes`. The ALU already routes the default case to b.
- Opcode constants (`OP_IMM`, `OP`, `OP_IMM32`, `OP32`, `LUI`, `AUIPC`) and a `decoded_t` struct (all out_* payload fields) belong in `pipes`.
- One sub-module, `alu_decoder`: a pure combinational instr/pc → `decoded_t` mapping. The top holds the register and handshake.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093): one cycle later → out_valid=1, ALU_ADD, imm=0xFFFF_FFFF_FFFF_FFFF, rd=1, srcb_imm=1, regwrite=1.
- SRAI x5,x6,63 (0x43F35293) → ALU_SRAI, imm=63, rs1=6, rd=5. LUI x2,0x80000 (0x80000137) → ALU_COPYB, imm=0xFFFF_FFFF_8000_0000.
- MUL x1,x2,x3 (0x023100B3) and SLLIW x1,x0,32 (0x0200109B) → illegal=1, regwrite=0, out_valid=1.
- Stall: out_ready=0 for 3 cycles while in_valid=1 with new words → in_ready=0, outputs frozen. Then out_ready=1 → the next instruction appears the following cycle with no loss or duplication.
- Flush with in_valid=1 and out_valid=1 in the same cycle → out_valid=0 next cycle. 100 random back-to-back ALU ops with out_ready=1 → 1/cycle throughput, in order, matching the reference decode.
- Reset asserted mid-stall (asynchronous, between edges) → all outputs 0 immediately. The first instruction after release is decoded correctly.

Source files
------------

// File: rtl/pipes.sv
// Shared pipeline types: ALU operation codes, RV64I opcode constants and the
// decoded payload carried from decode into execute.
package pipes;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLTI,
    ALU_SLTIU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLLI,
    ALU_SRLI,
    ALU_SRAI,
    ALU_ADDW,
    ALU_SUBW,
    ALU_SLLW,
    ALU_SRLW,
    ALU_SRAW,
    ALU_COPYB
  } alufunc_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP32     = 7'b0111011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alufunc_t     alufunc;
    logic         srca_pc;
    logic         srcb_imm;
    logic [63:0]  imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         regwrite;
    logic         illegal;
    logic [63:0]  pc;
    logic [31:0]  instr;
  } decoded_t;

endpackage

// File: rtl/alu_decoder.sv
// Pure combinational RV64I ALU-class decode: instruction word and PC in,
// complete decoded_t payload out.
module alu_decoder
  import pipes::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  output decoded_t    dec
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [63:0] imm_i;
  logic signed [63:0] imm_u;
  logic [63:0]        shamt6;
  logic [63:0]        shamt5;

  alufunc_t           func;
  logic               ill;
  logic               srca;
  logic               srcb;
  logic [63:0]        imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = 64'(signed'(instr[31:20]));
  assign imm_u  = 64'(signed'({instr[31:12], 12'b0}));
  assign shamt6 = {58'b0, instr[25:20]};
  assign shamt5 = {59'b0, instr[24:20]};

  always_comb begin
    func = ALU_COPYB;
    ill  = 1'b0;
    srca = 1'b0;
    srcb = 1'b0;
    imm  = '0;
    unique case (opcode)
      OP_IMM: begin
        srcb = 1'b1;
        imm  = imm_i;
        unique case (funct3)
          3'b000: func = ALU_ADD;
          3'b010: func = ALU_SLTI;
          3'b011: func = ALU_SLTIU;
          3'b100: func = ALU_XOR;
          3'b110: func = ALU_OR;
          3'b111: func = ALU_AND;
          3'b001: begin
            imm = shamt6;
            if (instr[31:26] == 6'b000000) func = ALU_SLLI;
            else                           ill  = 1'b1;
          end
          default: begin
            imm = shamt6;
            if (instr[31:26] == 6'b000000)      func = ALU_SRLI;
            else if (instr[31:26] == 6'b010000) func = ALU_SRAI;
            else                                ill  = 1'b1;
          end
        endcase
      end
      OP: begin
        if (funct7 == F7_ZERO) begin
          unique case (funct3)
            3'b000:  func = ALU_ADD;
            3'b001:  func = ALU_SLLI;
            3'b010:  func = ALU_SLTI;
            3'b011:  func = ALU_SLTIU;
            3'b100:  func = ALU_XOR;
            3'b101:  func = ALU_SRLI;
            3'b110:  func = ALU_OR;
            default: func = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          func = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          func = ALU_SRAI;
        end else begin
          ill = 1'b1;
        end
      end
      OP_IMM32: begin
        srcb = 1'b1;
        // funct7 covers instr[25], so a 6-bit shamt on a W shift is rejected here
        if (funct3 == 3'b000) begin
          func = ALU_ADDW;
          imm  = imm_i;
        end else if (funct3 == 3'b001 && funct7 == F7_ZERO) begin
          func = ALU_SLLW;
          imm  = shamt5;
        end else if (funct3 == 3'b101 && funct7 == F7_ZERO) begin
          func = ALU_SRLW;
          imm  = shamt5;
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          func = ALU_SRAW;
          imm  = shamt5;
        end else begin
          ill = 1'b1;
        end
      end
      OP32: begin
        if (funct3 == 3'b000 && funct7 == F7_ZERO)      func = ALU_ADDW;
        else if (funct3 == 3'b000 && funct7 == F7_ALT)  func = ALU_SUBW;
        else if (funct3 == 3'b001 && funct7 == F7_ZERO) func = ALU_SLLW;
        else if (funct3 == 3'b101 && funct7 == F7_ZERO) func = ALU_SRLW;
        else if (funct3 == 3'b101 && funct7 == F7_ALT)  func = ALU_SRAW;
        else                                            ill  = 1'b1;
      end
      LUI: begin
        func = ALU_COPYB;
        srcb = 1'b1;
        imm  = imm_u;
      end
      AUIPC: begin
        func = ALU_ADD;
        srca = 1'b1;
        srcb = 1'b1;
        imm  = imm_u;
      end
      default: ill = 1'b1;
    endcase

    // Illegal entries still flow downstream as a harmless copy of zero
    if (ill) begin
      func = ALU_COPYB;
      srca = 1'b0;
      srcb = 1'b0;
      imm  = '0;
    end
  end

  always_comb begin
    dec          = '0;
    dec.alufunc  = func;
    dec.srca_pc  = srca;
    dec.srcb_imm = srcb;
    dec.imm      = imm;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.regwrite = !ill && (instr[11:7] != 5'd0);
    dec.illegal  = ill;
    dec.pc       = pc;
    dec.instr    = instr;
  end

endmodule

// File: rtl/alu_decode.sv
// Decode stage for the execute-stage ALU: combinational decode into a one-entry
// output register with valid/ready handshake, stall and flush.
module alu_decode
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output alufunc_t    out_alufunc,
  output logic        out_srca_pc,
  output logic        out_srcb_imm,
  output logic [63:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        out_illegal,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  decoded_t dec_p0;
  decoded_t held_p1;
  logic     vld_p1;
  logic     accept;

  alu_decoder u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // p0 -> p1: capture on accept; flush discards both held and offered entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      held_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      held_p1 <= dec_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_alufunc  = held_p1.alufunc;
  assign out_srca_pc  = held_p1.srca_pc;
  assign out_srcb_imm = held_p1.srcb_imm;
  assign out_imm      = held_p1.imm;
  assign out_rs1      = held_p1.rs1;
  assign out_rs2      = held_p1.rs2;
  assign out_rd       = held_p1.rd;
  assign out_regwrite = held_p1.regwrite;
  assign out_illegal  = held_p1.illegal;
  assign out_pc       = held_p1.pc;
  assign out_instr    = held_p1.instr;

endmodule

// File: tb/tb_alu_decode.sv
// Bench for alu_decode: directed vector table, handshake corner sequences and
// randomized traffic against a rule-table reference decoder.
module tb_alu_decode;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  alufunc_t    out_alufunc;
  logic        out_srca_pc, out_srcb_imm, out_regwrite, out_illegal;
  logic [63:0] out_imm, out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_instr;

  int ntests = 0;
  int nfail  = 0;

  alu_decode dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_alufunc(out_alufunc),
    .out_srca_pc(out_srca_pc), .out_srcb_imm(out_srcb_imm), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_illegal(out_illegal),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Reference: list of legal encodings; immk 0 none, 1 I-type, 2 shamt6, 3 shamt5, 4 U-type
  typedef struct {
    logic [6:0] opc;
    int         f3;
    int         chk;
    logic [6:0] val;
    alufunc_t   fn;
    int         immk;
    logic       pcsel;
  } rule_t;
  rule_t rules[$];

  task automatic add(input logic [6:0] o, input int f, input int c, input logic [6:0] v,
                     input alufunc_t fn, input int ik, input logic p);
    rule_t r;
    r.opc = o; r.f3 = f; r.chk = c; r.val = v; r.fn = fn; r.immk = ik; r.pcsel = p;
    rules.push_back(r);
  endtask

  function automatic decoded_t ref_dec(input logic [31:0] i, input logic [63:0] pc);
    decoded_t d;
    bit hit;
    d = '0;
    d.pc = pc; d.instr = i;
    d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
    d.alufunc = ALU_COPYB;
    d.illegal = 1'b1;
    foreach (rules[k]) begin
      hit = (i[6:0] == rules[k].opc) &&
            (rules[k].f3 < 0 || int'(i[14:12]) == rules[k].f3) &&
            (rules[k].chk == 0 ||
             (rules[k].chk == 1 && i[31:26] == rules[k].val[5:0]) ||
             (rules[k].chk == 2 && i[31:25] == rules[k].val));
      if (hit) begin
        d.illegal  = 1'b0;
        d.alufunc  = rules[k].fn;
        d.srca_pc  = rules[k].pcsel;
        d.srcb_imm = (rules[k].immk != 0);
        case (rules[k].immk)
          1:       d.imm = 64'(signed'(i[31:20]));
          2:       d.imm = 64'(i[25:20]);
          3:       d.imm = 64'(i[24:20]);
          4:       d.imm = 64'(signed'(i[31:12])) * 64'd4096;
          default: d.imm = 64'd0;
        endcase
      end
    end
    d.regwrite = !d.illegal && (d.rd != 0);
    return d;
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [31:0] w;
    int k;
    k = $urandom_range(rules.size() - 1);
    w = $urandom;
    w[6:0] = rules[k].opc;
    if (rules[k].f3 >= 0) w[14:12] = 3'(rules[k].f3);
    if (rules[k].chk == 1) w[31:26] = rules[k].val[5:0];
    if (rules[k].chk == 2) w[31:25] = rules[k].val;
    return w;
  endfunction

  function automatic decoded_t get_out();
    decoded_t a;
    a.alufunc = out_alufunc; a.srca_pc = out_srca_pc; a.srcb_imm = out_srcb_imm;
    a.imm = out_imm; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
    a.regwrite = out_regwrite; a.illegal = out_illegal; a.pc = out_pc; a.instr = out_instr;
    return a;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model of the output slot
  bit       mvalid = 0;
  decoded_t mexp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string name, input logic v, input logic [31:0] ins,
                       input logic [63:0] pc, input logic ordy, input logic fl);
    bit rdy, acc;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    rdy = !mvalid || ordy;
    acc = v && rdy;
    check({name, "_in_ready"}, 192'(in_ready), 192'(rdy));
    step();
    if (fl)       mvalid = 0;
    else if (acc) begin mvalid = 1; mexp = ref_dec(ins, pc); end
    else if (ordy) mvalid = 0;
    check({name, "_out_valid"}, 192'(out_valid), 192'(mvalid));
    if (mvalid) check({name, "_payload"}, 192'(get_out()), 192'(mexp));
  endtask

  typedef struct {
    logic [31:0] instr;
    alufunc_t    fn;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        sa, sb, rw, ill;
  } vec_t;

  initial begin
    vec_t     vecs[$];
    decoded_t e;
    logic [31:0] wa, wb, wc, wd;

    add(7'h13, 0, 0, 0, ALU_ADD, 1, 0);   add(7'h13, 2, 0, 0, ALU_SLTI, 1, 0);
    add(7'h13, 3, 0, 0, ALU_SLTIU, 1, 0); add(7'h13, 4, 0, 0, ALU_XOR, 1, 0);
    add(7'h13, 6, 0, 0, ALU_OR, 1, 0);    add(7'h13, 7, 0, 0, ALU_AND, 1, 0);
    add(7'h13, 1, 1, 0, ALU_SLLI, 2, 0);  add(7'h13, 5, 1, 0, ALU_SRLI, 2, 0);
    add(7'h13, 5, 1, 7'd16, ALU_SRAI, 2, 0);
    add(7'h33, 0, 2, 0, ALU_ADD, 0, 0);   add(7'h33, 1, 2, 0, ALU_SLLI, 0, 0);
    add(7'h33, 2, 2, 0, ALU_SLTI, 0, 0);  add(7'h33, 3, 2, 0, ALU_SLTIU, 0, 0);
    add(7'h33, 4, 2, 0, ALU_XOR, 0, 0);   add(7'h33, 5, 2, 0, ALU_SRLI, 0, 0);
    add(7'h33, 6, 2, 0, ALU_OR, 0, 0);    add(7'h33, 7, 2, 0, ALU_AND, 0, 0);
    add(7'h33, 0, 2, 7'h20, ALU_SUB, 0, 0); add(7'h33, 5, 2, 7'h20, ALU_SRAI, 0, 0);
    add(7'h1B, 0, 0, 0, ALU_ADDW, 1, 0);  add(7'h1B, 1, 2, 0, ALU_SLLW, 3, 0);
    add(7'h1B, 5, 2, 0, ALU_SRLW, 3, 0);  add(7'h1B, 5, 2, 7'h20, ALU_SRAW, 3, 0);
    add(7'h3B, 0, 2, 0, ALU_ADDW, 0, 0);  add(7'h3B, 0, 2, 7'h20, ALU_SUBW, 0, 0);
    add(7'h3B, 1, 2, 0, ALU_SLLW, 0, 0);  add(7'h3B, 5, 2, 0, ALU_SRLW, 0, 0);
    add(7'h3B, 5, 2, 7'h20, ALU_SRAW, 0, 0);
    add(7'h37, -1, 0, 0, ALU_COPYB, 4, 0); add(7'h17, -1, 0, 0, ALU_ADD, 4, 1);

    //             instr         fn         imm                     rs1 rs2 rd  sa sb rw ill
    vecs.push_back('{32'hFFF00093, ALU_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 0,  31, 1,  0, 1, 1, 0});
    vecs.push_back('{32'h43F35293, ALU_SRAI,  64'd63,                  6,  31, 5,  0, 1, 1, 0});
    vecs.push_back('{32'h80000137, ALU_COPYB, 64'hFFFF_FFFF_8000_0000, 0,  0,  2,  0, 1, 1, 0});
    vecs.push_back('{32'h023100B3, ALU_COPYB, 64'd0,                   2,  3,  1,  0, 0, 0, 1});
    vecs.push_back('{32'h0200109B, ALU_COPYB, 64'd0,                   0,  0,  1,  0, 0, 0, 1});
    vecs.push_back('{32'h12345197, ALU_ADD,   64'h0000_0000_1234_5000, 8,  3,  3,  1, 1, 1, 0});
    vecs.push_back('{32'h409403B3, ALU_SUB,   64'd0,                   8,  9,  7,  0, 0, 1, 0});
    vecs.push_back('{32'h00000013, ALU_ADD,   64'd0,                   0,  0,  0,  0, 1, 0, 0});
    vecs.push_back('{32'h41F2D21B, ALU_SRAW,  64'd31,                  5,  31, 4,  0, 1, 1, 0});
    vecs.push_back('{32'h04005013, ALU_COPYB, 64'd0,                   0,  0,  0,  0, 0, 0, 1});
    vecs.push_back('{32'h00000003, ALU_COPYB, 64'd0,                   0,  0,  0,  0, 0, 0, 1});

    // Reset state, released between edges
    #3;
    check("reset_out_valid", 192'(out_valid), 192'(0));
    check("reset_payload", 192'(get_out()), 192'(0));
    #4 reset = 1'b0;

    // Directed table, back-to-back
    foreach (vecs[k]) begin
      in_valid = 1; in_instr = vecs[k].instr; in_pc = 64'h1000 + 64'(4 * k); out_ready = 1;
      step();
      e = '0;
      e.alufunc = vecs[k].fn; e.imm = vecs[k].imm;
      e.rs1 = vecs[k].rs1; e.rs2 = vecs[k].rs2; e.rd = vecs[k].rd;
      e.srca_pc = vecs[k].sa; e.srcb_imm = vecs[k].sb;
      e.regwrite = vecs[k].rw; e.illegal = vecs[k].ill;
      e.pc = 64'h1000 + 64'(4 * k); e.instr = vecs[k].instr;
      check($sformatf("vec%0d_valid", k), 192'(out_valid), 192'(1));
      check($sformatf("vec%0d_payload", k), 192'(get_out()), 192'(e));
    end
    cycle("drain", 0, 0, 0, 1, 0);

    // Stall: 3 cycles of out_ready=0 with changing input, then release
    wa = 32'h00500093; wb = 32'h00A00113; wc = 32'h40208233; wd = 32'h0FF00193;
    cycle("stall_a", 1, wa, 64'h2000, 1, 0);
    cycle("stall_1", 1, wb, 64'h2004, 0, 0);
    cycle("stall_2", 1, wc, 64'h2008, 0, 0);
    cycle("stall_3", 1, wd, 64'h200C, 0, 0);
    check("stall_hold_instr", 192'(out_instr), 192'(wa));
    cycle("stall_rel_b", 1, wb, 64'h2004, 1, 0);
    check("stall_next_instr", 192'(out_instr), 192'(wb));
    cycle("stall_rel_c", 1, wc, 64'h2008, 1, 0);
    cycle("stall_drain", 0, 0, 0, 1, 0);

    // Flush with held entry and an offered entry in the same cycle
    cycle("flush_fill", 1, wa, 64'h3000, 1, 0);
    cycle("flush_hit", 1, wb, 64'h3004, 1, 1);
    check("flush_valid", 192'(out_valid), 192'(0));
    cycle("flush_after", 0, 0, 0, 1, 0);
    cycle("flush_fill2", 1, wc, 64'h3008, 0, 0);
    cycle("flush_stalled", 1, wd, 64'h300C, 0, 1);

    // 100 random ALU ops back-to-back
    for (int n = 0; n < 100; n++)
      cycle("b2b", 1, gen_legal(), {$urandom, $urandom}, 1, 0);
    cycle("b2b_drain", 0, 0, 0, 1, 0);

    // Random handshake traffic, including illegal words and occasional flush
    for (int n = 0; n < 300; n++)
      cycle("rnd", ($urandom % 4) != 0,
            (($urandom % 4) == 0) ? 32'($urandom) : gen_legal(),
            {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 16) == 0);

    // Asynchronous reset asserted mid-stall
    cycle("rst_fill", 1, wa, 64'h4000, 1, 0);
    cycle("rst_stall", 1, wb, 64'h4004, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", 192'(out_valid), 192'(0));
    check("rst_mid_payload", 192'(get_out()), 192'(0));
    check("rst_mid_in_ready", 192'(in_ready), 192'(1));
    mvalid = 0;
    #1 reset = 1'b0;
    cycle("rst_first", 1, 32'hFFF00093, 64'h5000, 1, 0);
    cycle("rst_end", 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
